// File: rtl/nibble_demux_1x8_if.sv
// ---------------------------------------------------------------------------
// nibble_demux_1x8_if
// Bus bundle for the 1-to-8 nibble demultiplexer.
//   Input side : in_valid/in_ready handshake carrying in_data, in_mode,
//                in_sel and the in_flush level.
//   Output side: out_valid/out_ready handshake carrying the assembled
//                out_word, the lane-written out_mask and the out_dup flag.
// Modports:
//   master - producer of nibbles / consumer of words (testbench side)
//   slave  - the demultiplexer itself
// ---------------------------------------------------------------------------
interface nibble_demux_1x8_if #(
    parameter int LANES = 8,
    parameter int NIB_W = 4
);
    localparam int SEL_W = $clog2(LANES);

    logic                   in_valid;
    logic                   in_ready;
    logic [NIB_W-1:0]       in_data;
    logic                   in_mode;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*NIB_W-1:0] out_word;
    logic [LANES-1:0]       out_mask;
    logic                   out_dup;

    modport master (
        output in_valid, in_data, in_mode, in_sel, in_flush, out_ready,
        input  in_ready, out_valid, out_word, out_mask, out_dup
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_sel, in_flush, out_ready,
        output in_ready, out_valid, out_word, out_mask, out_dup
    );
endinterface

// File: rtl/nibble_demux_1x8.sv
// ---------------------------------------------------------------------------
// nibble_demux_1x8
// Registered 1-to-8 demultiplexer for 4-bit nibbles. Each accepted nibble is
// written into one of eight lane registers, chosen either by in_sel
// (addressed mode) or by an internal auto-incrementing pointer (sequential
// mode). When all lanes are written, or a flush closes a non-empty word, the
// assembled 32-bit word is offered on the output handshake and held until the
// consumer takes it.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - nibble_demux_1x8_if.slave (input beats and output word)
// ---------------------------------------------------------------------------
module nibble_demux_1x8 #(
    parameter int LANES = 8,
    parameter int NIB_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nibble_demux_1x8_if.slave      bus
);
    localparam int SEL_W = $clog2(LANES);

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LANES*NIB_W-1:0] r_lanes;
    logic [LANES-1:0]       r_mask;
    logic                   r_dup;
    logic [SEL_W-1:0]       r_ptr;

    logic [SEL_W-1:0]       w_lane;
    logic [LANES-1:0]       w_mask_set;
    logic [LANES-1:0]       w_mask_post;
    logic                   w_accept;
    logic                   w_release;
    logic                   w_in_ready;
    logic                   w_out_valid;

    assign w_lane      = bus.in_mode ? r_ptr : bus.in_sel;
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_release   = (r_state == S_HOLD) & bus.out_ready;
    assign w_mask_post = r_mask | w_mask_set;

    always_comb begin
        w_mask_set = '0;
        if (w_accept) begin
            w_mask_set[w_lane] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: the completion test uses the mask including the beat
    // accepted this cycle, so a flush alongside a beat still closes the word.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL: begin
                if ((&w_mask_post) || (bus.in_flush && (|w_mask_post))) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Output decode: in_ready is forced low while reset is asserted even
    // though the state already sits in FILL.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_FILL:  w_in_ready  = rst_n;
            S_HOLD:  w_out_valid = 1'b1;
            default: ;
        endcase
    end

    // Lane, mask, duplicate flag and pointer. Accept only happens in FILL, so
    // the word is frozen for the whole of HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lanes <= '0;
            r_mask  <= '0;
            r_dup   <= 1'b0;
            r_ptr   <= '0;
        end else if (w_release) begin
            r_lanes <= '0;
            r_mask  <= '0;
            r_dup   <= 1'b0;
            r_ptr   <= '0;
        end else if (w_accept) begin
            r_lanes[w_lane*NIB_W +: NIB_W] <= bus.in_data;
            r_mask                         <= w_mask_post;
            r_dup                          <= r_dup | r_mask[w_lane];
            r_ptr                          <= w_lane + 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_word  = r_lanes;
    assign bus.out_mask  = r_mask;
    assign bus.out_dup   = r_dup;

endmodule

// File: tb/tb_nibble_demux_1x8.sv
module tb_nibble_demux_1x8;

    typedef struct {
        logic        v;
        logic        mode;
        logic [2:0]  sel;
        logic [3:0]  data;
        logic        flush;
        logic        ordy;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_word;
        logic [7:0]  e_mask;
        logic        e_dup;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    vec_t tbl[$];

    nibble_demux_1x8_if bus ();

    nibble_demux_1x8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic v, logic mode, logic [2:0] sel, logic [3:0] data,
                                logic flush, logic ordy, logic e_rdy, logic e_vld,
                                logic [31:0] e_word, logic [7:0] e_mask, logic e_dup);
        vec_t r;
        r.v = v; r.mode = mode; r.sel = sel; r.data = data; r.flush = flush;
        r.ordy = ordy; r.e_rdy = e_rdy; r.e_vld = e_vld;
        r.e_word = e_word; r.e_mask = e_mask; r.e_dup = e_dup;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'h0;
        bus.in_mode   = 1'b0;
        bus.in_sel    = 3'd0;
        bus.in_flush  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    // One sequential-mode beat: driven at the falling edge, taken at the next
    // rising edge, inputs idled again at the following falling edge.
    task automatic seq_beat(input logic [3:0] d);
        bus.in_valid = 1'b1;
        bus.in_mode  = 1'b1;
        bus.in_data  = d;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
        rst_n = 1'b0;

        // --- reset state ---
        #12;
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_word",  bus.out_word,           32'd0);
        chk("rst_out_mask",  {24'd0, bus.out_mask},  32'd0);
        chk("rst_out_dup",   {31'd0, bus.out_dup},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // --- vector table: one row per clock, expectations after that edge ---
        // Sequential fill 1..8
        for (int i = 1; i <= 7; i++)
            tbl.push_back(mk(1, 1, 0, 4'(i), 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 4'h8, 0, 0, 0, 1, 32'h87654321, 8'hFF, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0, 1, 1, 0, 0, 0, 0));
        // Addressed 7/0/3 then flush
        tbl.push_back(mk(1, 0, 7, 4'hA, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 4'h5, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 3, 4'hC, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,    1, 0, 0, 1, 32'hA000C005, 8'h89, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0, 1, 1, 0, 0, 0, 0));
        // Overwrite lane 2
        tbl.push_back(mk(1, 0, 2, 4'h3, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 2, 4'h9, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,    1, 0, 0, 1, 32'h00000900, 8'h04, 1));
        tbl.push_back(mk(0, 0, 0, 0,    0, 1, 1, 0, 0, 0, 0));
        // Empty flush ignored, then flush together with a beat
        tbl.push_back(mk(0, 0, 0, 0,    1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 4'h4, 1, 0, 0, 1, 32'h00000004, 8'h01, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0, 1, 1, 0, 0, 0, 0));
        // Mixed modes with pointer wrap 7->0, then in_valid ignored in HOLD
        tbl.push_back(mk(1, 0, 6, 4'h1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 4'h2, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 4'h3, 1, 0, 0, 1, 32'h21000003, 8'hC1, 0));
        tbl.push_back(mk(1, 1, 0, 4'hF, 0, 0, 0, 1, 32'h21000003, 8'hC1, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0, 1, 1, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            bus.in_valid  = tbl[i].v;
            bus.in_mode   = tbl[i].mode;
            bus.in_sel    = tbl[i].sel;
            bus.in_data   = tbl[i].data;
            bus.in_flush  = tbl[i].flush;
            bus.out_ready = tbl[i].ordy;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i),  {31'd0, bus.in_ready},  {31'd0, tbl[i].e_rdy});
            chk($sformatf("vec%0d_out_valid", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].e_vld});
            if (tbl[i].e_vld) begin
                chk($sformatf("vec%0d_out_word", i), bus.out_word,          tbl[i].e_word);
                chk($sformatf("vec%0d_out_mask", i), {24'd0, bus.out_mask}, {24'd0, tbl[i].e_mask});
                chk($sformatf("vec%0d_out_dup", i),  {31'd0, bus.out_dup},  {31'd0, tbl[i].e_dup});
            end
        end
        idle_inputs();

        // --- backpressure: full word held for 5 clocks ---
        for (int i = 0; i < 8; i++) seq_beat(4'(i));
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
            chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_out_word",  bus.out_word,           32'h76543210);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_rel_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("bp_rel_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_rel_mask",      {24'd0, bus.out_mask},  32'd0);

        // --- reset mid-word ---
        for (int i = 1; i <= 4; i++) seq_beat(4'(i));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_out_word",  bus.out_word,           32'd0);
        chk("midrst_out_mask",  {24'd0, bus.out_mask},  32'd0);
        chk("midrst_out_dup",   {31'd0, bus.out_dup},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) seq_beat(4'hF);
        chk("after_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("after_rst_out_word",  bus.out_word,           32'hFFFFFFFF);
        chk("after_rst_out_mask",  {24'd0, bus.out_mask},  32'h000000FF);
        chk("after_rst_out_dup",   {31'd0, bus.out_dup},   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
